// File: rtl/otter_csr_pkg.sv
// otter_csr_pkg: shared CSR addresses, bit positions and helpers for the
// OTTER machine-mode CSR file and interrupt controller.
package otter_csr_pkg;

   // CSR addresses (ir[31:20])
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_CYCLE   = 12'hC00;
   localparam logic [11:0] CSR_CYCLEH  = 12'hC80;

   // Bit positions of the implemented single-bit fields
   localparam int MSTATUS_MIE_BIT  = 3;
   localparam int MSTATUS_MPIE_BIT = 7;
   localparam int MIE_MEIE_BIT     = 11;

   // mcause value for a machine external interrupt
   localparam logic [31:0] MCAUSE_MEXT = 32'h8000_000B;

   // Clear the two low bits; mtvec and mepc are always word aligned.
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/otter_csr_intr_sync.sv
// intr_sync_edge: multi-flop synchroniser for an asynchronous level input
// followed by a rising-edge detector producing a one-cycle pulse.
module intr_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic async_in,
   output logic rise_pulse
);

   logic [SYNC_STAGES-1:0] sync_p0;
   logic                   sync_p1;

   // Shift the raw pin through the synchroniser chain and keep the previous
   // synchronised level for edge detection.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_p0 <= '0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= {sync_p0[SYNC_STAGES-2:0], async_in};
         sync_p1 <= sync_p0[SYNC_STAGES-1];
      end
   end

   // --- edge detect: synchronised level high now, low one cycle ago ---
   assign rise_pulse = sync_p0[SYNC_STAGES-1] & ~sync_p1;

endmodule

// File: rtl/otter_csr_intr.sv
// otter_csr_intr: machine-mode CSR file and external interrupt controller
// for the multicycle OTTER MCU. Strobe priority is int_taken > mret_exec >
// csr_WE. Optional macro OTTER_CSR_MCYCLE_EN adds a 64-bit cycle counter
// readable at cycle (0xC00) and cycleh (0xC80).
module otter_csr_intr
   import otter_csr_pkg::*;
#(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        INTR,
   input  logic        csr_WE,
   input  logic        int_taken,
   input  logic        mret_exec,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wd,
   input  logic [31:0] pc,
   output logic [31:0] csr_rd,
   output logic [31:0] mtvec,
   output logic [31:0] mepc,
   output logic        mstatus_mie,
   output logic        intr_req
);

   logic        mstatus_mie_q;
   logic        mstatus_mpie_q;
   logic        mie_meie_q;
   logic [31:0] mtvec_q;
   logic [31:0] mepc_q;
   logic [31:0] mcause_q;
   logic        pending_q;
   logic        intr_rise;

   intr_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .CLK        (CLK),
      .RST        (RST),
      .async_in   (INTR),
      .rise_pulse (intr_rise)
   );

   // Architectural CSR updates: trap entry beats mret, which beats a software write.
   always_ff @(posedge CLK) begin
      if (RST) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_meie_q     <= 1'b0;
         mtvec_q        <= word_align(MTVEC_RESET);
         mepc_q         <= '0;
         mcause_q       <= '0;
      end else if (int_taken) begin
         mepc_q         <= word_align(pc);
         mcause_q       <= MCAUSE_MEXT;
         mstatus_mpie_q <= mstatus_mie_q;
         mstatus_mie_q  <= 1'b0;
      end else if (mret_exec) begin
         mstatus_mie_q  <= mstatus_mpie_q;
         mstatus_mpie_q <= 1'b1;
      end else if (csr_WE) begin
         case (csr_addr)
            CSR_MSTATUS: begin
               mstatus_mie_q  <= csr_wd[MSTATUS_MIE_BIT];
               mstatus_mpie_q <= csr_wd[MSTATUS_MPIE_BIT];
            end
            CSR_MIE:    mie_meie_q <= csr_wd[MIE_MEIE_BIT];
            CSR_MTVEC:  mtvec_q    <= word_align(csr_wd);
            CSR_MEPC:   mepc_q     <= word_align(csr_wd);
            CSR_MCAUSE: mcause_q   <= csr_wd;
            default: ;
         endcase
      end
   end

   // Pending latch: a new edge sets it, even in the cycle the trap clears it.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pending_q <= 1'b0;
      end else if (intr_rise) begin
         pending_q <= 1'b1;
      end else if (int_taken) begin
         pending_q <= 1'b0;
      end
   end

`ifdef OTTER_CSR_MCYCLE_EN
   logic [63:0] mcycle_q;

   // Free-running cycle counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         mcycle_q <= '0;
      end else begin
         mcycle_q <= mcycle_q + 64'd1;
      end
   end
`endif

   // Combinational read mux; unimplemented addresses return zero.
   always_comb begin
      csr_rd = '0;
      case (csr_addr)
         CSR_MSTATUS: begin
            csr_rd[MSTATUS_MIE_BIT]  = mstatus_mie_q;
            csr_rd[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
         end
         CSR_MIE:    csr_rd[MIE_MEIE_BIT] = mie_meie_q;
         CSR_MTVEC:  csr_rd = mtvec_q;
         CSR_MEPC:   csr_rd = mepc_q;
         CSR_MCAUSE: csr_rd = mcause_q;
`ifdef OTTER_CSR_MCYCLE_EN
         CSR_CYCLE:  csr_rd = mcycle_q[31:0];
         CSR_CYCLEH: csr_rd = mcycle_q[63:32];
`endif
         default:    csr_rd = '0;
      endcase
   end

   assign mtvec       = mtvec_q;
   assign mepc        = mepc_q;
   assign mstatus_mie = mstatus_mie_q;
   assign intr_req    = pending_q & mstatus_mie_q & mie_meie_q;

endmodule

// File: tb/tb_otter_csr_intr.sv
// tb_otter_csr_intr: self-checking bench for otter_csr_intr. Table-driven
// CSR write/read vectors plus hand-written interrupt sequences, with
// expected values queued on a scoreboard and popped at compare time.
module tb_otter_csr_intr;
   import otter_csr_pkg::*;

   localparam logic [31:0] MTVEC_RST = 32'h0000_1000;

   logic        CLK;
   logic        RST;
   logic        INTR;
   logic        csr_WE;
   logic        int_taken;
   logic        mret_exec;
   logic [11:0] csr_addr;
   logic [31:0] csr_wd;
   logic [31:0] pc;
   logic [31:0] csr_rd;
   logic [31:0] mtvec;
   logic [31:0] mepc;
   logic        mstatus_mie;
   logic        intr_req;

   otter_csr_intr #(
      .MTVEC_RESET (MTVEC_RST),
      .SYNC_STAGES (2)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .INTR        (INTR),
      .csr_WE      (csr_WE),
      .int_taken   (int_taken),
      .mret_exec   (mret_exec),
      .csr_addr    (csr_addr),
      .csr_wd      (csr_wd),
      .pc          (pc),
      .csr_rd      (csr_rd),
      .mtvec       (mtvec),
      .mepc        (mepc),
      .mstatus_mie (mstatus_mie),
      .intr_req    (intr_req)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } sb_t;

   typedef struct {
      logic [11:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_mie;
   } vec_t;

   sb_t  sb_q[$];
   vec_t vecs[8];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic expect_val(input string name, input logic [31:0] exp);
      sb_t e;
      e.name = name;
      e.exp  = exp;
      sb_q.push_back(e);
   endtask

   task automatic check_out(input logic [31:0] act);
      sb_t e;
      n_tests++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: got %h with nothing expected", act);
      end else begin
         e = sb_q.pop_front();
         if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
         end
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic read_csr(input logic [11:0] a, output logic [31:0] d);
      csr_addr = a;
      #1;
      d = csr_rd;
   endtask

   task automatic check_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
      logic [31:0] d;
      expect_val(name, exp);
      read_csr(a, d);
      check_out(d);
   endtask

   task automatic check_sig(input string name, input logic [31:0] act, input logic [31:0] exp);
      expect_val(name, exp);
      check_out(act);
   endtask

   task automatic write_csr(input logic [11:0] a, input logic [31:0] wd);
      csr_WE   = 1'b1;
      csr_addr = a;
      csr_wd   = wd;
      tick();
      csr_WE   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [31:0] d0;
      int          hits;

      RST = 1'b1; INTR = 1'b0; csr_WE = 1'b0; int_taken = 1'b0; mret_exec = 1'b0;
      csr_addr = '0; csr_wd = '0; pc = '0;

      vecs[0] = '{12'h305, 32'h0000_0103, 32'h0000_0100, 1'b0};
      vecs[1] = '{12'h300, 32'hFFFF_FFFF, 32'h0000_0088, 1'b1};
      vecs[2] = '{12'h304, 32'hFFFF_FFFF, 32'h0000_0800, 1'b1};
      vecs[3] = '{12'h341, 32'h1234_5677, 32'h1234_5674, 1'b1};
      vecs[4] = '{12'h342, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
      vecs[5] = '{12'h340, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
      vecs[6] = '{12'h300, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[7] = '{12'h304, 32'h0000_0800, 32'h0000_0800, 1'b0};

      // Reset values
      tick();
      RST = 1'b0;
      check_csr("rst_mstatus", CSR_MSTATUS, 32'h0);
      check_csr("rst_mie", CSR_MIE, 32'h0);
      check_csr("rst_mepc", CSR_MEPC, 32'h0);
      check_csr("rst_mcause", CSR_MCAUSE, 32'h0);
      check_sig("rst_mtvec", mtvec, MTVEC_RST);
      check_sig("rst_intr_req", {31'b0, intr_req}, 32'h0);
      check_sig("rst_mstatus_mie", {31'b0, mstatus_mie}, 32'h0);

      // Table-driven write masking
      for (int i = 0; i < 8; i++) begin
         expect_val($sformatf("vec%0d_rd", i), vecs[i].exp_rd);
         expect_val($sformatf("vec%0d_mie", i), {31'b0, vecs[i].exp_mie});
         write_csr(vecs[i].addr, vecs[i].wd);
         read_csr(vecs[i].addr, d);
         check_out(d);
         check_out({31'b0, mstatus_mie});
      end
      check_sig("mtvec_port", mtvec, 32'h0000_0100);
      check_sig("mepc_port", mepc, 32'h1234_5674);

      // Enabled interrupt: latency of SYNC_STAGES+1 edges
      write_csr(CSR_MSTATUS, 32'h0000_0008);
      INTR = 1'b1;
      tick();
      check_sig("lat_edge1", {31'b0, intr_req}, 32'h0);
      tick();
      check_sig("lat_edge2", {31'b0, intr_req}, 32'h0);
      tick();
      check_sig("lat_edge3", {31'b0, intr_req}, 32'h1);

      // Trap entry, with a simultaneous lower-priority mcause write ignored
      int_taken = 1'b1; pc = 32'h0000_0204;
      csr_WE = 1'b1; csr_addr = CSR_MCAUSE; csr_wd = 32'h0;
      tick();
      int_taken = 1'b0; csr_WE = 1'b0;
      check_sig("trap_mepc", mepc, 32'h0000_0204);
      check_csr("trap_mcause", CSR_MCAUSE, MCAUSE_MEXT);
      check_csr("trap_mstatus", CSR_MSTATUS, 32'h0000_0080);
      check_sig("trap_mie_out", {31'b0, mstatus_mie}, 32'h0);
      check_sig("trap_intr_req", {31'b0, intr_req}, 32'h0);

      // mret with a simultaneous mepc write that must be ignored
      mret_exec = 1'b1;
      csr_WE = 1'b1; csr_addr = CSR_MEPC; csr_wd = 32'h0;
      tick();
      mret_exec = 1'b0; csr_WE = 1'b0;
      check_csr("mret_mstatus", CSR_MSTATUS, 32'h0000_0088);
      check_sig("mret_mie_out", {31'b0, mstatus_mie}, 32'h1);
      check_sig("mret_mepc_kept", mepc, 32'h0000_0204);

      // INTR still high, enables set: no second request
      hits = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (intr_req) hits++;
      end
      check_sig("held_no_rerequest", hits, 32'h0);
      INTR = 1'b0;
      repeat (4) tick();

      // Masked pending
      write_csr(CSR_MSTATUS, 32'h0);
      INTR = 1'b1;
      repeat (3) tick();
      INTR = 1'b0;
      hits = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (intr_req) hits++;
      end
      check_sig("masked_req_low", hits, 32'h0);
      write_csr(CSR_MSTATUS, 32'h0000_0008);
      check_sig("unmask_req_high", {31'b0, intr_req}, 32'h1);
      int_taken = 1'b1; pc = 32'h0000_0300;
      tick();
      int_taken = 1'b0;
      check_sig("unmask_trap_clear", {31'b0, intr_req}, 32'h0);

      // INTR held high 20 cycles while masked: exactly one pending
      INTR = 1'b1;
      repeat (20) tick();
      write_csr(CSR_MSTATUS, 32'h0000_0008);
      check_sig("held_one_req", {31'b0, intr_req}, 32'h1);
      int_taken = 1'b1; pc = 32'h0000_0310;
      tick();
      int_taken = 1'b0;
      write_csr(CSR_MSTATUS, 32'h0000_0008);
      check_sig("held_no_second", {31'b0, intr_req}, 32'h0);
      INTR = 1'b0;
      repeat (4) tick();

      // Race: edge detected in the same cycle as int_taken
      INTR = 1'b1;
      tick();
      tick();
      int_taken = 1'b1; pc = 32'h0000_0400;
      tick();
      int_taken = 1'b0;
      check_sig("race_mepc", mepc, 32'h0000_0400);
      check_sig("race_req_masked", {31'b0, intr_req}, 32'h0);
      mret_exec = 1'b1;
      tick();
      mret_exec = 1'b0;
      check_sig("race_pending_kept", {31'b0, intr_req}, 32'h1);
      INTR = 1'b0;

      // Reset during a trap aborts the trap updates
      RST = 1'b1; int_taken = 1'b1; pc = 32'h0000_0888;
      tick();
      RST = 1'b0; int_taken = 1'b0;
      check_sig("rst_trap_mepc", mepc, 32'h0);
      check_csr("rst_trap_mcause", CSR_MCAUSE, 32'h0);
      check_sig("rst_trap_mtvec", mtvec, MTVEC_RST);
      check_sig("rst_trap_req", {31'b0, intr_req}, 32'h0);

`ifdef OTTER_CSR_MCYCLE_EN
      read_csr(CSR_CYCLE, d0);
      repeat (10) tick();
      read_csr(CSR_CYCLE, d);
      check_sig("cycle_delta", d - d0, 32'd10);
`else
      write_csr(CSR_CYCLE, 32'hFFFF_FFFF);
      check_csr("cycle_absent", CSR_CYCLE, 32'h0);
      check_csr("cycleh_absent", CSR_CYCLEH, 32'h0);
      d0 = 32'h0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
